// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and request legality/alignment helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

   function automatic logic f3_legal(input logic store, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!store)
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

   // Halfwords need addr[0]=0, words need addr[1:0]=00; stores share the codes.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if ((f3 == F3_H) || (f3 == F3_HU))
         bad = lo[0];
      else if (f3 == F3_W)
         bad = |lo;
      return bad;
   endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational data formatting: store lane replication and byte strobes,
// load lane extraction with sign/zero extension.
module lsu_fmt
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_strb,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Halfword strobes only look at addr[1], so a stray addr[0] is dropped here.
   always_comb begin
      st_strb  = 4'b0000;
      st_wdata = st_data;
      case (st_funct3)
         F3_B: begin
            st_strb  = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         F3_H: begin
            st_strb  = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         F3_W: st_strb = 4'b1111;
         default: st_strb = 4'b0000;
      endcase
   end

   assign lane_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
   assign lane_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      ld_data = 32'h0;
      case (ld_funct3)
         F3_B:  ld_data = {{24{lane_byte[7]}}, lane_byte};
         F3_BU: ld_data = {24'h0, lane_byte};
         F3_H:  ld_data = {{16{lane_half[15]}}, lane_half};
         F3_HU: ld_data = {16'h0, lane_half};
         F3_W:  ld_data = ld_word;
         default: ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding valid/ready bus transaction with response timeout.
// Define LSU_MISALIGN_CHK_EN to fault misaligned half/word accesses instead of forcing alignment.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t    state, state_nx;
   logic [CW-1:0] tmo_cnt;
   logic          is_store;
   logic [2:0]    funct3;
   logic [1:0]    addr_lo;
   logic          bad_align;
   logic          req_bad;
   logic          timed_out;
   logic [3:0]    fmt_strb;
   logic [31:0]   fmt_wdata;
   logic [31:0]   fmt_rdata;

`ifdef LSU_MISALIGN_CHK_EN
   assign bad_align = f3_misaligned(req_funct3, req_addr[1:0]);
`else
   assign bad_align = 1'b0;
`endif

   assign req_bad   = !f3_legal(req_store, req_funct3) || bad_align;
   assign timed_out = (tmo_cnt == CW'(TIMEOUT - 1));

   lsu_fmt u_fmt (
      .st_funct3  (req_funct3),
      .st_addr_lo (req_addr[1:0]),
      .st_data    (req_wdata),
      .st_strb    (fmt_strb),
      .st_wdata   (fmt_wdata),
      .ld_funct3  (funct3),
      .ld_addr_lo (addr_lo),
      .ld_word    (mem_rdata),
      .ld_data    (fmt_rdata)
   );

   assign req_ready = (state == IDLE);
   assign mem_valid = (state == REQ);
   assign rsp_valid = (state == DONE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req_valid) state_nx = req_bad ? DONE : REQ;
         REQ:  if (mem_ready) state_nx = RESP;
         RESP: if (mem_rvalid || timed_out) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A response arriving in the same cycle as the timeout still completes normally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         is_store  <= 1'b0;
         funct3    <= 3'b000;
         addr_lo   <= 2'b00;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wstrb <= 4'b0000;
         mem_wdata <= 32'h0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (req_valid) begin
               is_store  <= req_store;
               funct3    <= req_funct3;
               addr_lo   <= req_addr[1:0];
               mem_we    <= req_store;
               mem_addr  <= {req_addr[31:2], 2'b00};
               mem_wstrb <= req_store ? fmt_strb : 4'b0000;
               mem_wdata <= fmt_wdata;
               rsp_err   <= req_bad;
               rsp_rdata <= 32'h0;
            end
            REQ: if (mem_ready) tmo_cnt <= '0;
            RESP: begin
               tmo_cnt <= tmo_cnt + CW'(1);
               if (mem_rvalid) begin
                  rsp_err   <= mem_err;
                  rsp_rdata <= (mem_err || is_store) ? 32'h0 : fmt_rdata;
               end else if (timed_out) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a behavioural model of the
// load/store formatting and bus/timeout handshake rules.
module tb_lsu;

   localparam int TMO = 4;
`ifdef LSU_MISALIGN_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_err = 1'b0;

   int checks = 0;
   int errors = 0;

   lsu #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One full transaction: rw = cycles mem_ready stays low, d = RESP cycle
   // index carrying mem_rvalid (negative or >= TMO means no response).
   task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int rw, input int d, input logic be);
      int sz, lo, eff, lat, resp_cycles, k;
      logic legal, pre_err, got, exp_err;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata, mask, v, exp_rdata;

      sz    = 1 << (f3 % 4);
      lo    = addr % 4;
      legal = st ? (f3 <= 2) : ((f3 <= 2) || (f3 == 4) || (f3 == 5));
      pre_err = !legal || (CHK && ((lo % sz) != 0));
      eff   = lo - (lo % sz);
      exp_strb  = st ? 4'(((1 << sz) - 1) << eff) : 4'b0000;
      exp_wdata = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                  (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
      v    = (rd >> (8 * eff)) & mask;
      if (f3 < 4 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;

      checkOutput("ready_idle", req_ready, 1);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
      lat = 1;

      if (pre_err) begin
         checkOutput("err_rsp_valid", rsp_valid, 1);
         checkOutput("err_no_bus", mem_valid, 0);
         checkOutput("err_flag", rsp_err, 1);
         checkOutput("err_rdata", rsp_rdata, 0);
      end else begin
         for (int i = 0; i <= rw; i++) begin
            mem_ready  = (i == rw);
            mem_rvalid = (i < rw) ? 1'($urandom) : 1'b0;
            checkOutput("req_valid", mem_valid, 1);
            checkOutput("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
            checkOutput("req_we", mem_we, st);
            checkOutput("req_strb", mem_wstrb, exp_strb);
            if (st) checkOutput("req_wdata", mem_wdata, exp_wdata);
            @(posedge clk); @(negedge clk);
            lat++;
         end
         mem_ready = 1'b0; mem_rvalid = 1'b0;
         checkOutput("resp_no_valid", mem_valid, 0);
         resp_cycles = (d >= 0 && d < TMO) ? d + 1 : TMO;
         exp_err = (d >= 0 && d < TMO) ? be : 1'b1;
         exp_rdata = (exp_err || st) ? 32'h0 : v;
         k = 0; got = 1'b0;
         while (!got && k <= TMO + 2) begin
            if (k == d) begin mem_rvalid = 1'b1; mem_rdata = rd; mem_err = be; end
            @(posedge clk); @(negedge clk);
            mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
            k++; lat++;
            if (rsp_valid) got = 1'b1;
         end
         checkOutput("rsp_seen", got, 1);
         checkOutput("rsp_cycles", k, resp_cycles);
         checkOutput("rsp_latency", lat, 1 + rw + 1 + resp_cycles);
         checkOutput("rsp_err", rsp_err, exp_err);
         checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
      end
      @(posedge clk); @(negedge clk);
      checkOutput("rsp_one_cycle", rsp_valid, 0);
      checkOutput("ready_back", req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #12;
      @(negedge clk);
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_mem_valid", mem_valid, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_err", rsp_err, 0);
      checkOutput("rst_wstrb", mem_wstrb, 0);
      checkOutput("rst_rdata", rsp_rdata, 0);
      checkOutput("rst_addr", mem_addr, 0);
      checkOutput("rst_wdata", mem_wdata, 0);
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
      applyStimulus(0, 3'b000, 32'h2000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
      applyStimulus(0, 3'b100, 32'h2000_0003, 32'h0, 32'h80FF_1234, 0, 1, 0);
      applyStimulus(0, 3'b101, 32'h2000_0002, 32'h0, 32'h80FF_1234, 1, 0, 0);
      applyStimulus(1, 3'b000, 32'h3000_0001, 32'h0000_00A5, 32'h0, 0, 0, 0);
      applyStimulus(1, 3'b001, 32'h3000_0002, 32'h1234_5678, 32'h0, 0, 2, 0);
      applyStimulus(0, 3'b010, 32'h4000_0000, 32'h0, 32'hCAFE_F00D, 5, 0, 1);
      applyStimulus(0, 3'b010, 32'h4000_0010, 32'h0, 32'h1111_2222, 0, -1, 0);

      // Stale response while idle must not produce a completion.
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(posedge clk); @(negedge clk);
      mem_rvalid = 1'b0;
      checkOutput("stale_no_rsp", rsp_valid, 0);
      checkOutput("stale_ready", req_ready, 1);

      applyStimulus(0, 3'b010, 32'h5000_0006, 32'h0, 32'h0BAD_C0DE, 0, 0, 0);
      applyStimulus(0, 3'b001, 32'h5000_0001, 32'h0, 32'h8001_7F02, 0, TMO - 1, 0);
      applyStimulus(0, 3'b011, 32'h5000_0000, 32'h0, 32'h0, 0, 0, 0);
      applyStimulus(1, 3'b100, 32'h5000_0000, 32'h0, 32'h0, 0, 0, 0);

      // Reset while waiting in RESP aborts silently.
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6000_0000;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_ready = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("abort_mem_valid", mem_valid, 0);
      checkOutput("abort_rsp_valid", rsp_valid, 0);
      checkOutput("abort_ready", req_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      mem_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         mem_rvalid = 1'b0;
         checkOutput("abort_quiet", rsp_valid, 0);
      end

      for (int n = 0; n < 80; n++) begin
         int d;
         d = $urandom_range(0, 6);
         if (d == 6) d = -1;
         applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                       $urandom_range(0, 2), d, ($urandom_range(0, 4) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
